// File: rtl/bfs_mem_arbiter.sv
// bfs_mem_arbiter: round-robin read arbiter sharing one graph-memory read port among
// NUM_PORTS pulse-style requesters. One downstream read is outstanding at a time. A read
// that gets no mem_valid within TIMEOUT_CYCLES is answered with TIMEOUT_DATA.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_rd_en/addr    per-port one-cycle read request and byte address (32 bits per port)
//   rsp_valid/data    per-port one-cycle response pulse; data held until the next response
//   mem_addr/rd_en    downstream address (held) and one-cycle read pulse
//   mem_data/valid    downstream read data and one-cycle valid
//   busy              a request is pending or a read is in flight
//   reads_completed   count of non-timeout responses (wraps)
//   timeout_err       sticky timeout flag
//   proto_err         sticky per-port flag: a request pulse was dropped
//   clear_err         synchronous clear of the sticky flags (a same-cycle event wins)
module bfs_mem_arbiter #(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_PORTS-1:0]    req_rd_en,
  input  logic [NUM_PORTS*32-1:0] req_addr,
  output logic [NUM_PORTS-1:0]    rsp_valid,
  output logic [NUM_PORTS*32-1:0] rsp_data,
  output logic [31:0]             mem_addr,
  output logic                    mem_rd_en,
  input  logic [31:0]             mem_data,
  input  logic                    mem_valid,
  output logic                    busy,
  output logic [31:0]             reads_completed,
  output logic                    timeout_err,
  output logic [NUM_PORTS-1:0]    proto_err,
  input  logic                    clear_err
);

  localparam int unsigned PW = $clog2(NUM_PORTS);

  typedef enum logic {StIdle, StWait} state_e;

  state_e                     state_q;
  logic [NUM_PORTS-1:0]       pending_q, pending_d;
  logic [NUM_PORTS-1:0][31:0] addr_q;
  logic [NUM_PORTS-1:0][31:0] req_addr_a;
  logic [NUM_PORTS-1:0][31:0] rsp_data_q;
  logic [PW-1:0]              owner_q, last_grant_q;
  logic [31:0]                wait_cnt_q;

  logic [NUM_PORTS-1:0]       drop, accept, cand, grant_oh;
  logic                       grant_vld;
  logic [PW-1:0]              grant_idx;
  logic [31:0]                grant_addr;
  logic [31:0]                scan;
  logic                       timeout_hit;

  // Packed 2-D views share the flat bus layout: port p at bits [32p+31:32p].
  assign req_addr_a = req_addr;
  assign rsp_data   = rsp_data_q;
  assign busy       = (state_q != StIdle) | (|pending_q);

  always_comb begin
    drop = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      drop[p] = req_rd_en[p] &
                (pending_q[p] | ((state_q == StWait) && (owner_q == PW'(p))));
    end
    accept = req_rd_en & ~drop;
    cand   = pending_q | req_rd_en;

    // First candidate after the last grant, wrapping modulo NUM_PORTS.
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      scan = (32'(last_grant_q) + i) % NUM_PORTS;
      if (!grant_vld && cand[scan]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(scan);
      end
    end

    grant_oh = '0;
    if (state_q == StIdle && grant_vld) grant_oh[grant_idx] = 1'b1;
    pending_d = (pending_q | accept) & ~grant_oh;

    // A port granted in the cycle its pulse arrives has no latched address yet.
    grant_addr = pending_q[grant_idx] ? addr_q[grant_idx] : req_addr_a[grant_idx];

    // The wait counter only runs once the issue pulse has gone, so the timeout response
    // lands TIMEOUT_CYCLES+1 cycles after mem_rd_en.
    timeout_hit = (TIMEOUT_CYCLES != 0) && !mem_rd_en &&
                  (wait_cnt_q == TIMEOUT_CYCLES - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      pending_q       <= '0;
      addr_q          <= '0;
      owner_q         <= '0;
      last_grant_q    <= PW'(NUM_PORTS - 1);
      wait_cnt_q      <= '0;
      mem_addr        <= '0;
      mem_rd_en       <= 1'b0;
      rsp_valid       <= '0;
      rsp_data_q      <= '0;
      reads_completed <= '0;
      timeout_err     <= 1'b0;
      proto_err       <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      rsp_valid <= '0;
      pending_q <= pending_d;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (accept[p]) addr_q[p] <= req_addr_a[p];
      end
      proto_err <= (clear_err ? '0 : proto_err) | drop;
      if (clear_err) timeout_err <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (grant_vld) begin
            mem_addr     <= grant_addr;
            mem_rd_en    <= 1'b1;
            owner_q      <= grant_idx;
            last_grant_q <= grant_idx;
            wait_cnt_q   <= '0;
            state_q      <= StWait;
          end
        end
        StWait: begin
          if (mem_valid) begin
            rsp_data_q[owner_q] <= mem_data;
            rsp_valid[owner_q]  <= 1'b1;
            reads_completed     <= reads_completed + 32'd1;
            state_q             <= StIdle;
          end else if (timeout_hit) begin
            rsp_data_q[owner_q] <= TIMEOUT_DATA;
            rsp_valid[owner_q]  <= 1'b1;
            timeout_err         <= 1'b1;
            state_q             <= StIdle;
          end else if (!mem_rd_en) begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bfs_mem_arbiter.sv
// Self-checking bench for bfs_mem_arbiter: directed scenarios followed by a randomized
// phase checked against a transaction-level round-robin model.
module tb_bfs_mem_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_rd_en;
  logic [N*32-1:0] req_addr;
  logic [N-1:0]    rsp_valid;
  logic [N*32-1:0] rsp_data;
  logic [31:0]     mem_addr;
  logic            mem_rd_en;
  logic [31:0]     mem_data;
  logic            mem_valid;
  logic            busy;
  logic [31:0]     reads_completed;
  logic            timeout_err;
  logic [N-1:0]    proto_err;
  logic            clear_err;

  int errors = 0;
  int checks = 0;

  // Directed-phase scratch
  int          n_wait;
  int          cnt0, cnt1;
  logic        early;
  int          issues;

  // Reference model state
  logic [N-1:0] outst_m;
  logic [31:0]  addr_m [N];
  logic [N-1:0] proto_m;
  int           last_m, owner_m, rc_m, due, pick;
  bit           inflight_m, was_inflight, exp_rsp, exp_issue;
  logic [31:0]  dat_m, a;

  always #5 clk = ~clk;

  bfs_mem_arbiter #(
    .NUM_PORTS     (N),
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_DATA  (32'hDEADBEEF)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_rd_en      (req_rd_en),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .mem_addr       (mem_addr),
    .mem_rd_en      (mem_rd_en),
    .mem_data       (mem_data),
    .mem_valid      (mem_valid),
    .busy           (busy),
    .reads_completed(reads_completed),
    .timeout_err    (timeout_err),
    .proto_err      (proto_err),
    .clear_err      (clear_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_rd_en = '0;
    clear_err = 1'b0;
    mem_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int p, input logic [31:0] addr);
    req_rd_en[p]        = 1'b1;
    req_addr[p*32 +: 32] = addr;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_rd_en"}, mem_rd_en, 0);
    check({tag, " mem_addr"}, mem_addr, 0);
    check({tag, " rsp_valid"}, rsp_valid, 0);
    check({tag, " rsp_data"}, |rsp_data, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " reads"}, reads_completed, 0);
    check({tag, " timeout_err"}, timeout_err, 0);
    check({tag, " proto_err"}, proto_err, 0);
  endtask

  // Wait (bounded) for an issue, check its address, answer after `delay` cycles and check
  // the routed response.
  task automatic serve(input int p, input logic [31:0] addr, input logic [31:0] d,
                       input int delay, input string tag);
    int n = 0;
    while (!mem_rd_en && n < 20) begin
      step();
      n++;
    end
    check({tag, " issue"}, mem_rd_en, 1);
    check({tag, " addr"}, mem_addr, addr);
    repeat (delay) step();
    mem_valid = 1'b1;
    mem_data  = d;
    step();
    mem_valid = 1'b0;
    check({tag, " rsp_valid"}, rsp_valid, N'(1) << p);
    check({tag, " rsp_data"}, rsp_data[p*32 +: 32], d);
  endtask

  initial begin
    req_rd_en = '0;
    req_addr  = '0;
    mem_valid = 1'b0;
    mem_data  = '0;
    clear_err = 1'b0;
    rst_n     = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Single request: issue in cycle 1, memory answers in cycle 3, response in cycle 4.
    set_req(0, 32'h80);
    step();
    req_rd_en = '0;
    check("single issue", mem_rd_en, 1);
    check("single addr", mem_addr, 32'h80);
    check("single busy", busy, 1);
    step();
    check("single rd_en pulse", mem_rd_en, 0);
    check("single no early rsp", rsp_valid, 0);
    step();
    mem_valid = 1'b1;
    mem_data  = 32'h3;
    step();
    mem_valid = 1'b0;
    check("single rsp_valid", rsp_valid, 3'b001);
    check("single rsp_data", rsp_data[31:0], 32'h3);
    check("single reads", reads_completed, 1);
    check("single idle", busy, 0);

    // Simultaneous pair from reset, then round-robin ordering.
    do_reset();
    set_req(0, 32'h100);
    set_req(1, 32'h200);
    step();
    req_rd_en = '0;
    serve(0, 32'h100, 32'hA1, 1, "pair p0");
    serve(1, 32'h200, 32'hA2, 2, "pair p1");
    set_req(0, 32'h300);
    step();
    req_rd_en = '0;
    serve(0, 32'h300, 32'hA3, 1, "solo p0");
    set_req(0, 32'h100);
    set_req(1, 32'h200);
    step();
    req_rd_en = '0;
    serve(1, 32'h200, 32'hB2, 1, "repeat p1");
    serve(0, 32'h100, 32'hB1, 3, "repeat p0");
    check("pair proto", proto_err, 0);

    // Fairness: ports 0 and 1 keep re-requesting for 20 reads.
    do_reset();
    cnt0 = 0;
    cnt1 = 0;
    set_req(0, 32'h1000);
    set_req(1, 32'h2001);
    step();
    req_rd_en = '0;
    for (int i = 0; i < 20; i++) begin
      serve(i % 2, 32'h1000 * (i % 2 + 1) + i, 32'hF000 + i, 1 + i % 3, "fair");
      if (rsp_valid[0]) cnt0++;
      if (rsp_valid[1]) cnt1++;
      if (i < 18) begin
        set_req(i % 2, 32'h1000 * (i % 2 + 1) + i + 2);
        step();
        req_rd_en = '0;
      end
    end
    check("fair count p0", cnt0, 10);
    check("fair count p1", cnt1, 10);
    check("fair proto", proto_err, 0);
    check("fair reads", reads_completed, 20);

    // Timeout: no answer, response 9 cycles after the issue.
    set_req(2, 32'h7000);
    step();
    req_rd_en = '0;
    n_wait = 0;
    while (!mem_rd_en && n_wait < 20) begin
      step();
      n_wait++;
    end
    check("to issue", mem_rd_en, 1);
    check("to addr", mem_addr, 32'h7000);
    early = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      early = early | (|rsp_valid);
    end
    check("to not early", early, 0);
    step();
    check("to rsp_valid", rsp_valid, 3'b100);
    check("to rsp_data", rsp_data[64 +: 32], 32'hDEADBEEF);
    check("to flag", timeout_err, 1);
    check("to reads", reads_completed, 20);
    mem_valid = 1'b1;
    mem_data  = 32'h55;
    step();
    mem_valid = 1'b0;
    check("late valid rsp", rsp_valid, 0);
    step();
    check("late valid rsp2", rsp_valid, 0);
    check("late valid reads", reads_completed, 20);
    check("late valid busy", busy, 0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("to clear", timeout_err, 0);

    // Protocol error: port 1 pulses twice while its read is waiting.
    set_req(1, 32'h8000);
    step();
    req_rd_en = '0;
    check("proto issue", mem_rd_en, 1);
    check("proto addr", mem_addr, 32'h8000);
    set_req(1, 32'h8888);
    set_req(0, 32'h9000);
    step();
    req_rd_en = '0;
    set_req(1, 32'h8999);
    step();
    req_rd_en = '0;
    check("proto flag", proto_err, 3'b010);
    mem_valid = 1'b1;
    mem_data  = 32'hAB;
    step();
    mem_valid = 1'b0;
    check("proto rsp_valid", rsp_valid, 3'b010);
    check("proto rsp_data", rsp_data[32 +: 32], 32'hAB);
    serve(0, 32'h9000, 32'hCD, 2, "proto p0");
    issues = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (mem_rd_en) issues++;
    end
    check("proto no reissue", issues, 0);
    check("proto sticky", proto_err, 3'b010);
    // Drop and clear in the same cycle: the drop wins for port 0.
    set_req(0, 32'hA000);
    step();
    req_rd_en = '0;
    set_req(0, 32'hA004);
    clear_err = 1'b1;
    step();
    req_rd_en = '0;
    clear_err = 1'b0;
    check("clear vs drop", proto_err, 3'b001);
    mem_valid = 1'b1;
    mem_data  = 32'h11;
    step();
    mem_valid = 1'b0;
    check("clear vs drop rsp", rsp_valid, 3'b001);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("proto clear", proto_err, 0);

    // Reset while waiting with port 0 pending.
    set_req(1, 32'hB000);
    step();
    req_rd_en = '0;
    set_req(0, 32'hC000);
    step();
    req_rd_en = '0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midwait rst");
    step();
    step();
    rst_n     = 1'b1;
    mem_valid = 1'b1;
    mem_data  = 32'h66;
    step();
    mem_valid = 1'b0;
    check("post rst rsp", rsp_valid, 0);
    check("post rst reads", reads_completed, 0);
    check("post rst rd_en", mem_rd_en, 0);
    check("post rst busy", busy, 0);
    set_req(1, 32'hD000);
    step();
    req_rd_en = '0;
    serve(1, 32'hD000, 32'h77, 1, "post rst p1");
    check("post rst count", reads_completed, 1);

    // Randomized traffic against a transaction-level model.
    do_reset();
    outst_m    = '0;
    proto_m    = '0;
    last_m     = N - 1;
    owner_m    = 0;
    rc_m       = 0;
    due        = -1;
    inflight_m = 1'b0;
    exp_rsp    = 1'b0;
    dat_m      = '0;
    for (int c = 0; c < 430; c++) begin
      if (c > 0) begin
        was_inflight = inflight_m;
        if (exp_rsp) begin
          check("rnd rsp_valid", rsp_valid, N'(1) << owner_m);
          check("rnd rsp_data", rsp_data[owner_m*32 +: 32], dat_m);
          outst_m[owner_m] = 1'b0;
          inflight_m       = 1'b0;
          rc_m++;
        end else begin
          check("rnd no rsp", rsp_valid, 0);
        end
        exp_issue = !was_inflight && (outst_m != '0);
        check("rnd issue", mem_rd_en, exp_issue);
        if (exp_issue) begin
          pick = -1;
          for (int i = 1; i <= N; i++) begin
            if (pick < 0 && outst_m[(last_m + i) % N]) pick = (last_m + i) % N;
          end
          check("rnd addr", mem_addr, addr_m[pick]);
          inflight_m = 1'b1;
          owner_m    = pick;
          last_m     = pick;
          due        = c + int'($urandom_range(1, 4));
          dat_m      = $urandom;
        end
        check("rnd reads", reads_completed, rc_m);
        check("rnd proto", proto_err, proto_m);
        check("rnd busy", busy,
              inflight_m || ((outst_m & ~(inflight_m ? (N'(1) << owner_m) : N'(0))) != '0));
      end
      mem_valid = 1'b0;
      exp_rsp   = 1'b0;
      if (c == due) begin
        mem_valid = 1'b1;
        mem_data  = dat_m;
        exp_rsp   = 1'b1;
        due       = -1;
      end else if (!inflight_m && $urandom_range(0, 7) == 0) begin
        mem_valid = 1'b1;
        mem_data  = $urandom;
      end
      req_rd_en = '0;
      if (c < 400) begin
        for (int p = 0; p < N; p++) begin
          if ($urandom_range(0, 3) == 0) begin
            a = $urandom;
            set_req(p, a);
            if (outst_m[p]) begin
              proto_m[p] = 1'b1;
            end else begin
              outst_m[p] = 1'b1;
              addr_m[p]  = a;
            end
          end
        end
      end
      step();
    end
    check("rnd drained", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
